// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared state encoding, requester ids and default widths for the FP add arbiter
package fp_arb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MENT_WIDTH = 23;
  localparam int DEF_EXPO_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;
  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/floating_point_addition.sv
// floating_point_addition: combinational single-precision add/sub, truncating, denormals flushed to zero
module floating_point_addition
  import fp_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MENT_WIDTH = DEF_MENT_WIDTH,
  parameter int EXPO_WIDTH = DEF_EXPO_WIDTH
)(
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  opcode_in,
  output logic [DATA_WIDTH-1:0] res_out
);
  localparam int MW = MENT_WIDTH + 4;
  localparam int EMAX = (1 << EXPO_WIDTH) - 1;
  logic sa, sb, sr, swap;
  logic [EXPO_WIDTH-1:0] ea, eb, el, es;
  logic [MENT_WIDTH-1:0] fl, fs;
  logic [MW-1:0] ml, ms, mal;
  logic [MW:0] sum, norm;
  int sh, p, e;
  always_comb begin
    sa = a_in[DATA_WIDTH-1];
    sb = b_in[DATA_WIDTH-1] ^ opcode_in;
    ea = a_in[DATA_WIDTH-2 -: EXPO_WIDTH];
    eb = b_in[DATA_WIDTH-2 -: EXPO_WIDTH];
    swap = {ea, a_in[MENT_WIDTH-1:0]} < {eb, b_in[MENT_WIDTH-1:0]};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    fl = swap ? b_in[MENT_WIDTH-1:0] : a_in[MENT_WIDTH-1:0];
    fs = swap ? a_in[MENT_WIDTH-1:0] : b_in[MENT_WIDTH-1:0];
    sr = swap ? sb : sa;
    // hidden bit on top, three low bits keep alignment shifts from losing the carry-in
    ml = (el == '0) ? '0 : {1'b1, fl, 3'b000};
    ms = (es == '0) ? '0 : {1'b1, fs, 3'b000};
    sh = int'(el) - int'(es);
    mal = (sh >= MW) ? '0 : ms >> sh;
    sum = (sa ^ sb) ? {1'b0, ml} - {1'b0, mal} : {1'b0, ml} + {1'b0, mal};
    p = -1;
    for (int i = 0; i <= MW; i++) if (sum[i]) p = i;
    norm = sum;
    e = int'(el);
    if (p == MW) begin
      norm = sum >> 1;
      e = e + 1;
    end else if (p >= 0) begin
      norm = sum << (MW - 1 - p);
      e = e - (MW - 1 - p);
    end
    res_out = (p < 0 || e <= 0) ? '0 :
              (e >= EMAX) ? {sr, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}} :
              {sr, EXPO_WIDTH'(e), MENT_WIDTH'(norm >> 3)};
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end sharing one FP adder between two requesters
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MENT_WIDTH = DEF_MENT_WIDTH,
  parameter int EXPO_WIDTH = DEF_EXPO_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req0_valid_in,
  output logic                  req0_ready_out,
  input  logic [DATA_WIDTH-1:0] req0_a_in,
  input  logic [DATA_WIDTH-1:0] req0_b_in,
  input  logic                  req0_opcode_in,
  input  logic                  req1_valid_in,
  output logic                  req1_ready_out,
  input  logic [DATA_WIDTH-1:0] req1_a_in,
  input  logic [DATA_WIDTH-1:0] req1_b_in,
  input  logic                  req1_opcode_in,
  output logic                  res_valid_out,
  input  logic                  res_ready_in,
  output logic [DATA_WIDTH-1:0] res_data_out,
  output logic                  res_id_out,
  output logic                  busy_out,
  output logic [CNT_WIDTH-1:0]  ops_done_out
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d, sum;
  logic op_q, op_d, id_q, id_d, last_id_q, last_id_d, res_id_q, res_id_d;
  logic gnt_id, idle_gnt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  floating_point_addition #(
    .DATA_WIDTH(DATA_WIDTH),
    .MENT_WIDTH(MENT_WIDTH),
    .EXPO_WIDTH(EXPO_WIDTH)
  ) u_fpadd (
    .a_in(a_q),
    .b_in(b_q),
    .opcode_in(op_q),
    .res_out(sum)
  );
  always_comb begin
    gnt_id = (req0_valid_in && req1_valid_in) ? ~last_id_q : (req1_valid_in ? ID1 : ID0);
    idle_gnt = state_q == IDLE && !rst_in && (req0_valid_in || req1_valid_in);
    req0_ready_out = idle_gnt && gnt_id == ID0;
    req1_ready_out = idle_gnt && gnt_id == ID1;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    id_d = id_q;
    last_id_d = last_id_q;
    res_data_d = res_data_q;
    res_id_d = res_id_q;
    cnt_d = cnt_q;
    if (idle_gnt) begin
      state_d = EXEC;
      a_d = gnt_id ? req1_a_in : req0_a_in;
      b_d = gnt_id ? req1_b_in : req0_b_in;
      op_d = gnt_id ? req1_opcode_in : req0_opcode_in;
      id_d = gnt_id;
      last_id_d = gnt_id;
    end else if (state_q == EXEC) begin
      state_d = DONE;
      res_data_d = sum;
      res_id_d = id_q;
    end else if (state_q == DONE && res_ready_in) begin
      state_d = IDLE;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      id_q <= ID0;
      last_id_q <= ID1;
      res_data_q <= '0;
      res_id_q <= ID0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      id_q <= id_d;
      last_id_q <= last_id_d;
      res_data_q <= res_data_d;
      res_id_q <= res_id_d;
      cnt_q <= cnt_d;
    end
  end
  assign res_valid_out = state_q == DONE;
  assign busy_out = state_q != IDLE;
  assign res_data_out = res_data_q;
  assign res_id_out = res_id_q;
  assign ops_done_out = cnt_q;
endmodule
